// File: rtl/conv3x3_pass_engine.sv
// 3x3 valid-region convolution responder: on a pass_in rising edge, streams one image
// from the source RAM through a 9-tap MAC and writes saturated results to the result RAM.
module conv3x3_pass_engine #(
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16,
    parameter int PIX_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int OADDR_W = 8,
    parameter int ACC_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pass_in,
    input  logic [35:0]        kernel,
    input  logic [3:0]         shift,
    output logic               busy,
    output logic               done_out,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIX_W-1:0]   rd_data,
    output logic               wr_en,
    output logic [OADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]   wr_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic                      pass_prev_q;
    logic [35:0]               kernel_q, kernel_d;
    logic [3:0]                shift_q, shift_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [RW-1:0]             r_q, r_d;
    logic [CW-1:0]             c_q, c_d;
    logic [3:0]                tap_q, tap_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic                      wr_en_q, wr_en_d;
    logic [OADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]          wr_data_q, wr_data_d;

    logic                      start;
    logic [3:0]                kidx;
    logic [3:0]                coef4;
    logic signed [ACC_W-1:0]   coef_s, pix_s, prod;

    function automatic logic [ADDR_W-1:0] src_addr(input logic [RW-1:0] r,
                                                   input logic [CW-1:0] c,
                                                   input logic [3:0]    t);
        logic [3:0] ty;
        logic [3:0] tx;
        ty = t / 4'd3;
        tx = t % 4'd3;
        return (ADDR_W'(r) + ADDR_W'(ty)) * ADDR_W'(IMG_W) + ADDR_W'(c) + ADDR_W'(tx);
    endfunction

    function automatic logic [PIX_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a,
                                                   input logic [3:0]              sh);
        logic signed [ACC_W-1:0] v;
        v = a >>> sh;
        if (v[ACC_W-1])     return '0;
        else if (v > PIX_MAX) return '1;
        else                return v[PIX_W-1:0];
    endfunction

    assign start = ~rst & (state_q == S_IDLE) & pass_in & ~pass_prev_q;

    // rd_data arriving this cycle belongs to the tap issued one cycle earlier.
    assign kidx   = (state_q == S_LOAD && tap_q != 4'd0) ? tap_q - 4'd1 : tap_q;
    assign coef4  = kernel_q[{kidx, 2'b00} +: 4];
    assign coef_s = {{(ACC_W-4){coef4[3]}}, coef4};
    assign pix_s  = ACC_W'(rd_data);
    assign prod   = pix_s * coef_s;

    always_comb begin
        state_d   = state_q;
        kernel_d  = kernel_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        r_d       = r_q;
        c_d       = c_q;
        tap_d     = tap_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kernel_d  = kernel;
                    shift_d   = shift;
                    r_d       = '0;
                    c_d       = '0;
                    tap_d     = '0;
                    state_d   = S_LOAD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end
            end
            S_LOAD: begin
                acc_d = (tap_q == 4'd0) ? '0 : acc_q + prod;
                if (tap_q == 4'd8) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d     = tap_q + 4'd1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = src_addr(r_q, c_q, tap_q + 4'd1);
                end
            end
            S_DRAIN: begin
                acc_d     = acc_q + prod;
                state_d   = S_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = OADDR_W'(r_q) * OADDR_W'(IMG_W - 2) + OADDR_W'(c_q);
                wr_data_d = sat_shift(acc_q + prod, shift_q);
            end
            S_WRITE: begin
                if (c_q == CW'(IMG_W - 3) && r_q == RW'(IMG_H - 3)) begin
                    r_d     = '0;
                    c_d     = '0;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (c_q == CW'(IMG_W - 3)) begin
                        c_d = '0;
                        r_d = r_q + RW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                    tap_d     = '0;
                    state_d   = S_LOAD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = src_addr(r_d, c_d, 4'd0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pass_prev_q <= 1'b0;
            kernel_q    <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            tap_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pass_prev_q <= pass_in;
            kernel_q    <= kernel_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            c_q         <= c_d;
            tap_q       <= tap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // busy also covers the start cycle itself, before the state register moves.
    assign busy     = busy_q | start;
    assign done_out = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_conv3x3_pass_engine.sv
// Randomized self-checking bench for conv3x3_pass_engine on a 4x4 image against a
// plain-arithmetic convolution model.
module tb_conv3x3_pass_engine;

    localparam int W        = 4;
    localparam int H        = 4;
    localparam int OW       = W - 2;
    localparam int OH       = H - 2;
    localparam int NPIX     = OW * OH;
    localparam int PASS_CYC = NPIX * 11 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pass_in = 1'b0;
    logic [35:0] kernel = '0;
    logic [3:0]  shift = '0;
    logic        busy, done_out, rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr, wr_data;
    logic [7:0]  rd_data = '0;
    logic [7:0]  mem [256];

    conv3x3_pass_engine #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pass_in(pass_in), .kernel(kernel), .shift(shift),
        .busy(busy), .done_out(done_out), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Source RAM: data only meaningful one cycle after rd_en, noise otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0, last_wr = -1, ovl = 0, gap_err = 0, done_cnt = 0;
    int wa_q[$];
    int wd_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (wr_en) begin
                wa_q.push_back(int'(wr_addr));
                wd_q.push_back(int'(wr_data));
                if (last_wr >= 0 && cyc - last_wr != 11) gap_err++;
                last_wr = cyc;
            end
            if (rd_en && wr_en) ovl++;
            if (done_out) done_cnt++;
        end
    end

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        last_wr  = -1;
        ovl      = 0;
        gap_err  = 0;
        done_cnt = 0;
    endtask

    function automatic int kv(input int i);
        logic signed [3:0] k4;
        k4 = kernel[4*i +: 4];
        return int'(k4);
    endfunction

    task automatic set_all_k(input logic [3:0] v);
        for (int i = 0; i < 9; i++) kernel[4*i +: 4] = v;
    endtask

    task automatic fill_mem(input int mode, input int val);
        for (int i = 0; i < 256; i++)
            mem[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'(val) : 8'($urandom);
    endtask

    task automatic run_pass(input string tag, input int hold, input bit mid);
        int exp_d[NPIX];
        int n_lim, done_at, busy_low, s, nw;
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                s = 0;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        s += int'(mem[(r + ky) * W + c + kx]) * kv(ky * 3 + kx);
                s = s >>> int'(shift);
                exp_d[r * OW + c] = (s < 0) ? 0 : (s > 255) ? 255 : s;
            end
        clear_mon();
        done_at  = 0;
        busy_low = 0;
        @(negedge clk);
        pass_in = 1'b1;
        n_lim = ((hold > PASS_CYC) ? hold : PASS_CYC) + 3;
        for (int n = 1; n <= n_lim; n++) begin
            @(negedge clk);
            if (n >= hold) pass_in = 1'b0;
            if (mid && n == 20) begin
                kernel = {4'($urandom), $urandom()};
                shift  = 4'($urandom);
            end
            if (done_out && done_at == 0) done_at = n;
            if (n <= PASS_CYC && !busy) busy_low++;
        end
        chk({tag, "_done_cycle"}, done_at, PASS_CYC);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_in_pass_low"}, busy_low, 0);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_nwrites"}, wa_q.size(), NPIX);
        nw = (wa_q.size() < NPIX) ? wa_q.size() : NPIX;
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
            chk($sformatf("%s_data%0d", tag, i), wd_q[i], exp_d[i]);
        end
        chk({tag, "_rd_wr_overlap"}, ovl, 0);
        chk({tag, "_wr_spacing"}, gap_err, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done_out), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_wr_data"}, int'(wr_data), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        fill_mem(0, 0);
        kernel = '0;
        kernel[19:16] = 4'd1;
        shift = 4'd0;
        run_pass("identity", 1, 1'b0);

        fill_mem(1, 255);
        set_all_k(4'd1);
        run_pass("sat_high", 1, 1'b0);

        kernel = '0;
        kernel[19:16] = 4'hF;
        run_pass("sat_neg", 1, 1'b0);

        fill_mem(1, 100);
        set_all_k(4'd1);
        shift = 4'd3;
        run_pass("shift3_midchange", 1, 1'b1);

        fill_mem(2, 0);
        set_all_k(4'd2);
        kernel[7:4] = 4'hD;
        shift = 4'd2;
        run_pass("held", 200, 1'b0);
        run_pass("reraise", 1, 1'b0);

        fill_mem(0, 0);
        kernel = '0;
        kernel[19:16] = 4'd1;
        shift = 4'd0;
        clear_mon();
        @(negedge clk);
        pass_in = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            pass_in = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        chk("midreset_partial_writes", wa_q.size(), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midreset_no_done", done_cnt, 0);
        run_pass("after_reset", 1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            fill_mem(2, 0);
            kernel = {4'($urandom), $urandom()};
            shift  = 4'($urandom_range(0, 6));
            run_pass($sformatf("rand%0d", k), 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
